// File: rtl/batalha_pkg.sv
// Shared types and helpers for the naval-battle attack controller.
package batalha_pkg;

  // Game phases of the attack controller.
  typedef enum logic [2:0] {
    OCIOSO,
    JOGANDO,
    AVALIA,
    FEEDBACK,
    VITORIA,
    DERROTA
  } estado_t;

  // Flat bit position of cell (col, lin) in the map/matrix vectors.
  // The row count is passed in so every instance size can share it.
  function automatic int indice(input int col, input int lin, input int linhas);
    return col * linhas + lin;
  endfunction

endpackage

// File: rtl/controlador_de_ataque_detector_de_borda.sv
// Registered rising-edge detector for the debounced fire button.
module detector_de_borda (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sinal_i,
  output logic borda_o
);

  logic anterior_q;

  // Remember last cycle's sample so a held level yields one pulse only.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) anterior_q <= 1'b0;
    else         anterior_q <= sinal_i;
  end

  assign borda_o = sinal_i & ~anterior_q;

endmodule

// File: rtl/controlador_de_ataque.sv
// Attack manager: validates shots, reveals hits, counts lives and
// detects victory/defeat for the LED-matrix naval-battle game.
module controlador_de_ataque
  import batalha_pkg::*;
#(
  parameter int LINHAS          = 7,
  parameter int COLUNAS         = 5,
  parameter int VIDAS           = 3,
  parameter int FEEDBACK_CICLOS = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         confirmar,
  input  logic [$clog2(COLUNAS)-1:0]   coordColuna,
  input  logic [$clog2(LINHAS)-1:0]    coordLinha,
  input  logic [LINHAS*COLUNAS-1:0]    mapa,
  output logic [LINHAS*COLUNAS-1:0]    matriz,
  output logic [$clog2(VIDAS+1)-1:0]   vida,
  output logic                         tem_vida,
  output logic                         LED_R,
  output logic                         LED_G,
  output logic                         LED_B,
  output logic                         venceu
);

  localparam int N  = LINHAS * COLUNAS;
  localparam int WC = $clog2(COLUNAS);
  localparam int WL = $clog2(LINHAS);
  localparam int WV = $clog2(VIDAS + 1);
  localparam int WF = $clog2(FEEDBACK_CICLOS + 1);
  localparam logic [N-1:0] UM = N'(1);

  estado_t         estado_q, estado_d;
  logic [N-1:0]    matriz_q, matriz_d;
  logic [N-1:0]    tiros_q, tiros_d;
  logic [WV-1:0]   vida_q, vida_d;
  logic [WC-1:0]   colAlvo_q, colAlvo_d;
  logic [WL-1:0]   linAlvo_q, linAlvo_d;
  logic [WF-1:0]   contador_q, contador_d;
  logic            ledR_q, ledR_d;
  logic            ledG_q, ledG_d;
  logic            ledB_q, ledB_d;
  logic            venceu_q, venceu_d;

  logic            pulso;
  logic            dentroFaixa;
  logic            tiroInedito;
  logic [N-1:0]    mascaraEntrada;
  logic [N-1:0]    mascaraAlvo;

  detector_de_borda uBorda (
    .clk_i   (clock),
    .rst_ni  (reset),
    .sinal_i (confirmar),
    .borda_o (pulso)
  );

  // Out-of-range coordinates never form a mask, so they can never be
  // mistaken for an already-fired cell or touch the shot registers.
  assign dentroFaixa    = (int'(coordColuna) < COLUNAS) && (int'(coordLinha) < LINHAS);
  assign mascaraEntrada = dentroFaixa
                          ? (UM << indice(int'(coordColuna), int'(coordLinha), LINHAS))
                          : '0;
  assign tiroInedito    = dentroFaixa && ((tiros_q & mascaraEntrada) == '0);
  assign mascaraAlvo    = UM << indice(int'(colAlvo_q), int'(linAlvo_q), LINHAS);

  // Next-state and register updates; enable low overrides everything.
  always_comb begin
    estado_d   = estado_q;
    matriz_d   = matriz_q;
    tiros_d    = tiros_q;
    vida_d     = vida_q;
    colAlvo_d  = colAlvo_q;
    linAlvo_d  = linAlvo_q;
    contador_d = contador_q;
    ledR_d     = ledR_q;
    ledG_d     = ledG_q;
    ledB_d     = ledB_q;
    venceu_d   = venceu_q;

    if (!enable) begin
      estado_d   = OCIOSO;
      matriz_d   = '0;
      tiros_d    = '0;
      vida_d     = WV'(VIDAS);
      contador_d = '0;
      ledR_d     = 1'b0;
      ledG_d     = 1'b0;
      ledB_d     = 1'b0;
      venceu_d   = 1'b0;
    end else begin
      unique case (estado_q)
        OCIOSO: begin
          matriz_d   = '0;
          tiros_d    = '0;
          vida_d     = WV'(VIDAS);
          contador_d = '0;
          ledR_d     = 1'b0;
          ledG_d     = 1'b0;
          ledB_d     = 1'b0;
          venceu_d   = 1'b0;
          estado_d   = JOGANDO;
        end
        JOGANDO: begin
          if (pulso && tiroInedito) begin
            colAlvo_d = coordColuna;
            linAlvo_d = coordLinha;
            estado_d  = AVALIA;
          end
        end
        AVALIA: begin
          tiros_d = tiros_q | mascaraAlvo;
          if ((mapa & mascaraAlvo) != '0) begin
            matriz_d = matriz_q | mascaraAlvo;
            ledG_d   = 1'b1;
            ledR_d   = 1'b0;
            if (matriz_d == mapa) begin
              venceu_d = 1'b1;
              estado_d = VITORIA;
            end else begin
              contador_d = '0;
              estado_d   = FEEDBACK;
            end
          end else begin
            vida_d = (vida_q == '0) ? '0 : vida_q - WV'(1);
            ledG_d = 1'b0;
            if (vida_d == '0) begin
              ledR_d   = 1'b0;
              ledB_d   = 1'b1;
              estado_d = DERROTA;
            end else begin
              ledR_d     = 1'b1;
              contador_d = '0;
              estado_d   = FEEDBACK;
            end
          end
        end
        FEEDBACK: begin
          if (contador_q == WF'(FEEDBACK_CICLOS - 1)) begin
            ledR_d     = 1'b0;
            ledG_d     = 1'b0;
            contador_d = '0;
            estado_d   = JOGANDO;
          end else begin
            contador_d = contador_q + WF'(1);
          end
        end
        VITORIA, DERROTA: begin
          estado_d = estado_q;
        end
        default: estado_d = OCIOSO;
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q   <= OCIOSO;
      matriz_q   <= '0;
      tiros_q    <= '0;
      vida_q     <= WV'(VIDAS);
      colAlvo_q  <= '0;
      linAlvo_q  <= '0;
      contador_q <= '0;
      ledR_q     <= 1'b0;
      ledG_q     <= 1'b0;
      ledB_q     <= 1'b0;
      venceu_q   <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      matriz_q   <= matriz_d;
      tiros_q    <= tiros_d;
      vida_q     <= vida_d;
      colAlvo_q  <= colAlvo_d;
      linAlvo_q  <= linAlvo_d;
      contador_q <= contador_d;
      ledR_q     <= ledR_d;
      ledG_q     <= ledG_d;
      ledB_q     <= ledB_d;
      venceu_q   <= venceu_d;
    end
  end

  assign matriz   = matriz_q;
  assign vida     = vida_q;
  assign tem_vida = (vida_q != '0);
  assign LED_R    = ledR_q;
  assign LED_G    = ledG_q;
  assign LED_B    = ledB_q;
  assign venceu   = venceu_q;

endmodule

// File: tb/tb_controlador_de_ataque.sv
// Self-checking bench for controlador_de_ataque: directed game scenarios
// plus randomized games scored against a cell-set model of the rules.
module tb_controlador_de_ataque;

  localparam int LIN = 7;
  localparam int COL = 5;
  localparam int VID = 3;
  localparam int FB  = 4;
  localparam int N   = LIN * COL;
  localparam logic [N-1:0] UM = N'(1);

  localparam int K_IGN  = 0;
  localparam int K_HIT  = 1;
  localparam int K_MISS = 2;
  localparam int K_VIT  = 3;
  localparam int K_DER  = 4;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         enable = 1'b0;
  logic         confirmar = 1'b0;
  logic [2:0]   coordColuna = '0;
  logic [2:0]   coordLinha = '0;
  logic [N-1:0] mapa = '0;
  logic [N-1:0] matriz;
  logic [1:0]   vida;
  logic         tem_vida, LED_R, LED_G, LED_B, venceu;

  logic         enable2 = 1'b0;
  logic         confirmar2 = 1'b0;
  logic [2:0]   coordColuna2 = '0;
  logic [2:0]   coordLinha2 = '0;
  logic [63:0]  mapa2 = '0;
  logic [63:0]  matriz2;
  logic [2:0]   vida2;
  logic         tem_vida2, LED_R2, LED_G2, LED_B2, venceu2;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: plain per-cell flags and a life count.
  bit navio[COL][LIN];
  bit tirado[COL][LIN];
  bit revelado[COL][LIN];
  int refVida;
  bit refVenceu;
  bit refDerrota;

  controlador_de_ataque dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .confirmar   (confirmar),
    .coordColuna (coordColuna),
    .coordLinha  (coordLinha),
    .mapa        (mapa),
    .matriz      (matriz),
    .vida        (vida),
    .tem_vida    (tem_vida),
    .LED_R       (LED_R),
    .LED_G       (LED_G),
    .LED_B       (LED_B),
    .venceu      (venceu)
  );

  controlador_de_ataque #(
    .LINHAS(8), .COLUNAS(8), .VIDAS(5), .FEEDBACK_CICLOS(4)
  ) dut8 (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable2),
    .confirmar   (confirmar2),
    .coordColuna (coordColuna2),
    .coordLinha  (coordLinha2),
    .mapa        (mapa2),
    .matriz      (matriz2),
    .vida        (vida2),
    .tem_vida    (tem_vida2),
    .LED_R       (LED_R2),
    .LED_G       (LED_G2),
    .LED_B       (LED_B2),
    .venceu      (venceu2)
  );

  always #5 clock = ~clock;

  // One comparison: counts it, and on mismatch counts and reports it.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] packRevelado();
    logic [N-1:0] v;
    v = '0;
    for (int c = 0; c < COL; c++)
      for (int l = 0; l < LIN; l++)
        if (revelado[c][l]) v = v | (UM << (c * LIN + l));
    return v;
  endfunction

  task automatic modelReset();
    for (int c = 0; c < COL; c++)
      for (int l = 0; l < LIN; l++) begin
        navio[c][l]    = ((mapa & (UM << (c * LIN + l))) != '0);
        tirado[c][l]   = 1'b0;
        revelado[c][l] = 1'b0;
      end
    refVida    = VID;
    refVenceu  = 1'b0;
    refDerrota = 1'b0;
  endtask

  function automatic int modelShot(input int col, input int lin);
    int naviosTotal, achados;
    if (refVenceu || refDerrota) return K_IGN;
    if (col >= COL || lin >= LIN) return K_IGN;
    if (tirado[col][lin]) return K_IGN;
    tirado[col][lin] = 1'b1;
    if (navio[col][lin]) begin
      revelado[col][lin] = 1'b1;
      naviosTotal = 0;
      achados = 0;
      for (int c = 0; c < COL; c++)
        for (int l = 0; l < LIN; l++) begin
          naviosTotal += int'(navio[c][l]);
          achados     += int'(revelado[c][l]);
        end
      if (achados == naviosTotal) begin
        refVenceu = 1'b1;
        return K_VIT;
      end
      return K_HIT;
    end
    refVida = (refVida > 0) ? refVida - 1 : 0;
    if (refVida == 0) begin
      refDerrota = 1'b1;
      return K_DER;
    end
    return K_MISS;
  endfunction

  // Fire one shot, holding the button `hold` cycles, and score the
  // two-cycle latency, the resulting state and the LED pulse lengths.
  task automatic applyStimulus(input int col, input int lin, input int hold);
    int kind, w, nR, nG, expR, expG;
    logic [N-1:0] antes;
    int vidaAntes;
    antes     = packRevelado();
    vidaAntes = refVida;
    kind      = modelShot(col, lin);
    w         = ((hold > FB + 2) ? hold : FB + 2) + 2;
    coordColuna = 3'(col);
    coordLinha  = 3'(lin);
    confirmar   = 1'b1;
    nR = 0;
    nG = 0;
    for (int cyc = 1; cyc <= w; cyc++) begin
      @(negedge clock);
      if (cyc == hold) confirmar = 1'b0;
      if (cyc == 1) begin
        checkOutput("matriz_latencia", 64'(matriz), 64'(antes));
        checkOutput("vida_latencia", 64'(vida), 64'(vidaAntes));
      end
      if (cyc == 2) begin
        checkOutput("matriz", 64'(matriz), 64'(packRevelado()));
        checkOutput("vida", 64'(vida), 64'(refVida));
        checkOutput("tem_vida", 64'(tem_vida), 64'(refVida != 0));
        checkOutput("venceu", 64'(venceu), 64'(refVenceu));
        checkOutput("LED_B", 64'(LED_B), 64'(refDerrota));
      end
      if (cyc >= 2) begin
        nR += int'(LED_R);
        nG += int'(LED_G);
      end
    end
    expR = (kind == K_MISS) ? FB : 0;
    expG = refVenceu ? (w - 1) : ((kind == K_HIT) ? FB : 0);
    checkOutput("LED_R_ciclos", 64'(nR), 64'(expR));
    checkOutput("LED_G_ciclos", 64'(nG), 64'(expG));
    checkOutput("matriz_final", 64'(matriz), 64'(packRevelado()));
    checkOutput("vida_final", 64'(vida), 64'(refVida));
  endtask

  // Drop enable for one cycle (loading a new map) and expect a fresh game.
  task automatic pulseEnable(input logic [N-1:0] novoMapa);
    enable = 1'b0;
    @(negedge clock);
    mapa   = novoMapa;
    enable = 1'b1;
    @(negedge clock);
    modelReset();
    checkOutput("enable_matriz", 64'(matriz), 64'(0));
    checkOutput("enable_vida", 64'(vida), 64'(VID));
    checkOutput("enable_leds", 64'({LED_R, LED_G, LED_B, venceu}), 64'(0));
  endtask

  initial begin
    logic [N-1:0] mapaAleatorio;
    int c, l, naviosTotal;

    mapa = N'(3);
    @(negedge clock);
    checkOutput("reset_matriz", 64'(matriz), 64'(0));
    checkOutput("reset_vida", 64'(vida), 64'(VID));
    checkOutput("reset_tem_vida", 64'(tem_vida), 64'(1));
    checkOutput("reset_leds", 64'({LED_R, LED_G, LED_B, venceu}), 64'(0));
    checkOutput("reset_vida8", 64'(vida2), 64'(5));

    reset  = 1'b1;
    enable = 1'b1;
    @(negedge clock);
    modelReset();

    $display("[TB] hit then victory");
    applyStimulus(0, 0, 1);
    applyStimulus(0, 1, 1);
    applyStimulus(2, 2, 1);

    $display("[TB] misses, repeat, out of range, defeat");
    pulseEnable(N'(3));
    applyStimulus(1, 0, 1);
    applyStimulus(1, 0, 1);
    applyStimulus(6, 0, 1);
    applyStimulus(0, 7, 1);
    applyStimulus(2, 0, 2);
    applyStimulus(3, 0, 1);
    applyStimulus(0, 0, 1);

    $display("[TB] held button");
    pulseEnable(N'(3));
    applyStimulus(4, 6, 20);

    $display("[TB] reset during feedback");
    coordColuna = 3'd0;
    coordLinha  = 3'd0;
    confirmar   = 1'b1;
    @(negedge clock);
    confirmar = 1'b0;
    @(negedge clock);
    checkOutput("fb_LED_G", 64'(LED_G), 64'(1));
    checkOutput("fb_matriz", 64'(matriz), 64'(1));
    #2 reset = 1'b0;
    #1;
    checkOutput("rst_async_matriz", 64'(matriz), 64'(0));
    checkOutput("rst_async_vida", 64'(vida), 64'(VID));
    checkOutput("rst_async_leds", 64'({LED_R, LED_G, LED_B, venceu}), 64'(0));
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    modelReset();

    $display("[TB] enable drop during evaluation");
    coordColuna = 3'd0;
    coordLinha  = 3'd0;
    confirmar   = 1'b1;
    @(negedge clock);
    enable    = 1'b0;
    confirmar = 1'b0;
    @(negedge clock);
    enable = 1'b1;
    @(negedge clock);
    checkOutput("aborta_matriz", 64'(matriz), 64'(0));
    checkOutput("aborta_vida", 64'(vida), 64'(VID));
    checkOutput("aborta_LED_G", 64'(LED_G), 64'(0));
    applyStimulus(0, 0, 1);

    $display("[TB] randomized games");
    for (int g = 0; g < 8; g++) begin
      mapaAleatorio = N'({$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom});
      pulseEnable(mapaAleatorio);
      naviosTotal = 0;
      for (int i = 0; i < N; i++)
        naviosTotal += int'((mapaAleatorio & (UM << i)) != '0);
      for (int s = 0; s < 30 && !(refVenceu || refDerrota); s++) begin
        c = $urandom_range(0, 7);
        l = $urandom_range(0, 7);
        if (naviosTotal > 0 && $urandom_range(0, 2) != 0) begin
          for (int t = 0; t < 100; t++) begin
            c = $urandom_range(0, COL - 1);
            l = $urandom_range(0, LIN - 1);
            if (navio[c][l] && !tirado[c][l]) break;
          end
        end
        applyStimulus(c, l, $urandom_range(1, 3));
      end
      applyStimulus($urandom_range(0, COL - 1), $urandom_range(0, LIN - 1), 1);
    end

    $display("[TB] 8x8 corner cell");
    mapa2   = 64'h8000_0000_0000_0000;
    enable2 = 1'b1;
    @(negedge clock);
    @(negedge clock);
    coordColuna2 = 3'd7;
    coordLinha2  = 3'd7;
    confirmar2   = 1'b1;
    @(negedge clock);
    confirmar2 = 1'b0;
    @(negedge clock);
    checkOutput("canto_matriz8", matriz2, 64'h8000_0000_0000_0000);
    checkOutput("canto_venceu8", 64'(venceu2), 64'(1));
    checkOutput("canto_vida8", 64'(vida2), 64'(5));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/controlador_de_ataque.md
# controlador_de_ataque

Parametrised, clocked successor to the attack manager of the naval-battle game. Takes a player shot (column/row coordinate plus a confirm button), reveals hits on an R×C LED matrix, decrements lives on misses, ignores repeated and out-of-range shots, and detects victory and defeat. It sits between the coordinate/button inputs and the LED-matrix driver. The ship map `mapa` comes from the map selector.

## Interface
- `LINHAS`, 7: matrix rows (≥2)
- `COLUNAS`, 5: matrix columns (≥2)
- `VIDAS`, 3: lives at start (≥1)
- `FEEDBACK_CICLOS`, 4: cycles the hit/miss LED stays lit after a shot (≥1)
- `clock` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-low reset
- `enable` in 1: game active; low returns block to idle (synchronous)
- `confirmar` in 1: debounced fire button, level; block detects rising edge
- `coordColuna` in `$clog2(COLUNAS)`: shot column
- `coordLinha` in `$clog2(LINHAS)`: shot row
- `mapa` in `LINHAS*COLUNAS`: ship map, bit `c*LINHAS+l`; stable while `enable`=1
- `matriz` out `LINHAS*COLUNAS`: revealed hits, same layout as `mapa`
- `vida` out `$clog2(VIDAS+1)`: remaining lives
- `tem_vida` out 1: `vida` != 0
- `LED_R` out 1: miss feedback
- `LED_G` out 1: hit feedback; steady in victory
- `LED_B` out 1: defeat
- `venceu` out 1: all ship cells revealed

## Operation
- Reset values: `matriz`=0, `tiros`(internal shot mask)=0, `vida`=VIDAS, all LEDs 0, `venceu`=0, state OCIOSO, edge register=0.
- States: OCIOSO, JOGANDO, AVALIA, FEEDBACK, VITORIA, DERROTA.
- OCIOSO:
  - Clears `matriz`, `tiros` and LEDs; loads `vida`=VIDAS.
  - `enable`=1 → JOGANDO.
- Any state with `enable`=0 → OCIOSO at the next edge. This takes priority over every other transition.
- JOGANDO, on a confirm pulse (`confirmar`=1 and previous sample 0):
  - Out of range (`coordColuna`≥COLUNAS or `coordLinha`≥LINHAS): ignored, stay in JOGANDO.
  - Cell already set in `tiros`: ignored, no penalty, no feedback.
  - Otherwise: latch coordinates → AVALIA.
- AVALIA: set `tiros` bit.
  - Hit (`mapa` bit = 1): set `matriz` bit.
    - If the new `matriz`==`mapa` → VITORIA.
    - Else → FEEDBACK with `LED_G`=1.
  - Miss: `vida`−1.
    - If the result is 0 → DERROTA.
    - Else → FEEDBACK with `LED_R`=1.
- FEEDBACK: counter runs FEEDBACK_CICLOS cycles, then LEDs → 0 and state → JOGANDO. Confirm pulses during FEEDBACK are dropped, not queued.
- VITORIA: `venceu`=1, `LED_G`=1, `matriz` frozen. Left only via `enable`=0 or reset.
- DERROTA: `LED_B`=1, `tem_vida`=0, `matriz` frozen. Left only via `enable`=0 or reset.
- `vida` never underflows; it saturates at 0.
- All-zero `mapa`: first valid shot is a miss. Victory is never reached, because it is only checked after a hit.

## Timing
- Edge detect: `confirmar` registered once. A pulse is seen at edge k, the first edge sampling 1 after a 0.
- Edge k: coordinates latched, state → AVALIA.
- Edge k+1: `matriz`, `vida`, LEDs and next state update. Shot-to-output latency is 2 cycles from the first high sample.
- FEEDBACK LED is high for exactly FEEDBACK_CICLOS cycles. The first cycle with the state back in JOGANDO accepts a new pulse.
- A button held high produces exactly one shot.
- `reset` low mid-shot: immediate reset values, no partial update.
- `enable` falling during AVALIA: OCIOSO wins, and the shot is discarded.

## Structure
- Package `batalha_pkg`:
  - state enum `estado_t`
  - function `indice(col, lin)` = `col*LINHAS+lin`
- Sub-module `detector_de_borda`: 1-bit registered rising-edge detector, async active-low reset.
- Everything else lives in one module: state register, feedback counter, `vida` counter, `matriz`/`tiros` registers.
- Target size is about 200 lines of RTL.

## Test plan
- Defaults, `mapa` with ship cells {(0,0),(0,1)} only, `enable`=1:
  - Shoot (0,0): `matriz` bit 0 = 1 two cycles after the press, `LED_G` high for 4 cycles.
  - Shoot (0,1): VITORIA, `venceu`=1, `LED_G` steady.
- Same map, misses at (1,0), (2,0), (3,0):
  - `vida` goes 3→2→1→0.
  - `LED_R` pulses twice.
  - Third miss → DERROTA, `LED_B`=1, `tem_vida`=0.
- Miss at (1,0) twice: second shot ignored, `vida` stays 2, no LED activity.
- Out-of-range shots, each ignored with state unchanged:
  - `coordColuna`=6 with COLUNAS=5
  - `coordLinha`=7 with LINHAS=7
- `confirmar` held high for 20 cycles: exactly one shot registered.
- Pulse `enable` low for one cycle after two hits: `matriz`=0, `vida`=3, state JOGANDO once `enable`=1.
- Pull `reset` low during FEEDBACK: outputs return to reset values asynchronously.
- Instance with LINHAS=8, COLUNAS=8, VIDAS=5: corner shot (7,7) maps to bit 63.
